risc_core_p: RTL and testbench

RISC_CORE_P -- requirements
Module: risc_core_p

---
 rtl/risc_core_p.sv | 107 ++++++++++
 tb/tb_risc_core_p.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_core_p.sv
// Accumulator-based 8-phase micro-sequenced core.
// Host access to the unified memory is allowed only while halted.
module risc_core_p #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              ext_we,
  input  logic [AWIDTH-1:0] ext_addr,
  input  logic [DWIDTH-1:0] ext_wdata,
  output logic [DWIDTH-1:0] ext_rdata,
  output logic              halt,
  output logic [AWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] acc,
  output logic [2:0]        phase,
  output logic [CNTW-1:0]   instr_cnt
);

  typedef enum logic {
    S_HALT,
    S_RUN
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  state_t              state;
  logic [DWIDTH-1:0]   mem [2**AWIDTH];
  logic [DWIDTH-1:0]   ir;
  logic [2:0]          op;
  logic [AWIDTH-1:0]   opa;
  logic [DWIDTH-1:0]   opd;
  logic                running;
  logic                unused_ir;

  assign op        = ir[DWIDTH-1 -: 3];
  assign opa       = ir[AWIDTH-1:0];
  assign opd       = mem[opa];
  assign unused_ir = ^ir;
  assign running   = (state == S_RUN);
  assign halt      = (state == S_HALT);
  assign ext_rdata = running ? '0 : mem[ext_addr];

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HALT;
      pc        <= '0;
      acc       <= '0;
      phase     <= '0;
      ir        <= '0;
      instr_cnt <= '0;
    end else if (!running) begin
      phase <= '0;
      if (go) state <= S_RUN;
    end else begin
      phase <= phase + 3'd1;
      case (phase)
        3'd3: ir <= mem[pc];
        3'd4: begin
          pc <= pc + AWIDTH'(1);
          // HLT retires here; the remaining phases never run
          if (op == OP_HLT) begin
            state     <= S_HALT;
            phase     <= '0;
            instr_cnt <= sat_inc(instr_cnt);
          end
        end
        3'd6: if (op == OP_SKZ && acc == '0) pc <= pc + AWIDTH'(1);
        3'd7: begin
          instr_cnt <= sat_inc(instr_cnt);
          unique case (1'b1)
            op == OP_ADD: acc <= acc + opd;
            op == OP_AND: acc <= acc & opd;
            op == OP_XOR: acc <= acc ^ opd;
            op == OP_LDA: acc <= opd;
            op == OP_JMP: pc  <= opa;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!running && ext_we)
        mem[ext_addr] <= ext_wdata;
      else if (running && phase == 3'd7 && op == OP_STO)
        mem[opa] <= acc;
    end
  end

endmodule

// File: tb/tb_risc_core_p.sv
// Scoreboard bench for risc_core_p: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_risc_core_p;

  logic       clk = 0;
  logic       rst = 1;
  logic       go = 0;
  logic       ext_we = 0;
  logic [4:0] ext_addr = '0;
  logic [7:0] ext_wdata = '0;
  logic [7:0] ext_rdata;
  logic       halt;
  logic [4:0] pc;
  logic [7:0] acc;
  logic [2:0] phase;
  logic [15:0] instr_cnt;

  risc_core_p #(.AWIDTH(5), .DWIDTH(8), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .go(go), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .halt(halt), .pc(pc), .acc(acc),
    .phase(phase), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  localparam int S_HALT = 0, S_PC = 1, S_ACC = 2;
  localparam int S_PH = 3, S_CNT = 4, S_RD = 5;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  logic probe = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_HALT: return 32'(halt);
      S_PC:   return 32'(pc);
      S_ACC:  return 32'(acc);
      S_PH:   return 32'(phase);
      S_CNT:  return 32'(instr_cnt);
      default: return 32'(ext_rdata);
    endcase
  endfunction

  always @(negedge clk) begin
    if (probe) begin
      while (sbq.size() > 0) begin
        exp_t e;
        logic [31:0] a;
        e = sbq.pop_front();
        a = actual(e.sel);
        checks++;
        if (a !== e.val) begin
          failures++;
          $display("FAIL %s: got %0h expected %0h", e.name, a, e.val);
        end
      end
    end
  end

  task automatic expect_v(input int sel, input logic [31:0] v,
                          input string name);
    exp_t e;
    e.sel = sel; e.val = v; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic check_now();
    probe = 1;
    @(negedge clk);
    #1;
    probe = 0;
  endtask

  task automatic expect_mem(input logic [4:0] a, input logic [7:0] v,
                            input string name);
    ext_addr = a;
    expect_v(S_RD, 32'(v), name);
    check_now();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    ext_we = 1; ext_addr = a; ext_wdata = d;
    tick();
    ext_we = 0;
  endtask

  task automatic pulse_go();
    go = 1;
    tick();
    go = 0;
  endtask

  task automatic run_to_halt(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (halt) break;
    end
  endtask

  initial begin
    tick();
    do_reset();
    expect_v(S_HALT, 1, "rst_halt");
    expect_v(S_PC, 0, "rst_pc");
    expect_v(S_ACC, 0, "rst_acc");
    expect_v(S_PH, 0, "rst_phase");
    expect_v(S_CNT, 0, "rst_cnt");
    check_now();

    // LDA 16 / ADD 17 / STO 18 / HLT
    wr(0, 8'hB0); wr(1, 8'h51); wr(2, 8'hD2); wr(3, 8'h00);
    wr(16, 8'h05); wr(17, 8'h07);
    pulse_go();
    repeat (3) tick();
    expect_v(S_HALT, 0, "prog_running");
    check_now();
    expect_mem(0, 8'h00, "rdata_zero_running");
    repeat (28) tick();
    expect_v(S_HALT, 1, "prog_halt");
    expect_v(S_ACC, 32'h0C, "prog_acc");
    expect_v(S_PC, 4, "prog_pc");
    expect_v(S_CNT, 4, "prog_cnt");
    expect_v(S_PH, 0, "prog_phase");
    check_now();
    expect_mem(18, 8'h0C, "prog_sto");

    // SKZ taken with acc=0
    do_reset();
    wr(0, 8'h20); wr(1, 8'h00); wr(2, 8'h00);
    pulse_go();
    run_to_halt(40);
    expect_v(S_HALT, 1, "skz_t_halt");
    expect_v(S_PC, 3, "skz_t_pc");
    expect_v(S_CNT, 2, "skz_t_cnt");
    check_now();

    // SKZ not taken: acc=05 via LDA, JMP 4, SKZ, HLT
    do_reset();
    wr(0, 8'hB0); wr(1, 8'hE4); wr(4, 8'h20); wr(5, 8'h00);
    wr(6, 8'h51); wr(7, 8'h00); wr(16, 8'h05);
    pulse_go();
    run_to_halt(60);
    expect_v(S_HALT, 1, "skz_n_halt");
    expect_v(S_PC, 6, "skz_n_pc");
    expect_v(S_ACC, 5, "skz_n_acc");
    expect_v(S_CNT, 4, "skz_n_cnt");
    check_now();

    // resume continues at pc with acc and count preserved
    pulse_go();
    run_to_halt(30);
    expect_v(S_HALT, 1, "resume_halt");
    expect_v(S_PC, 8, "resume_pc");
    expect_v(S_ACC, 32'h0C, "resume_acc");
    expect_v(S_CNT, 6, "resume_cnt");
    check_now();

    // JMP 0 loop; go and ext_we while running are ignored
    do_reset();
    wr(0, 8'hE0);
    pulse_go();
    repeat (5) tick();
    go = 1; ext_we = 1; ext_addr = 0; ext_wdata = 8'h00;
    tick();
    go = 0; ext_we = 0;
    repeat (74) tick();
    expect_v(S_HALT, 0, "loop_run");
    expect_v(S_PC, 0, "loop_pc");
    expect_v(S_CNT, 10, "loop_cnt");
    expect_v(S_PH, 0, "loop_phase");
    check_now();
    do_reset();
    expect_mem(0, 8'hE0, "loop_mem_kept");

    // ADD wraps modulo 256
    wr(0, 8'hB0); wr(1, 8'h51); wr(2, 8'h00);
    wr(16, 8'hFF); wr(17, 8'h01);
    pulse_go();
    run_to_halt(40);
    expect_v(S_ACC, 0, "addwrap_acc");
    expect_v(S_PC, 3, "addwrap_pc");
    expect_v(S_CNT, 3, "addwrap_cnt");
    check_now();

    // reset during phase 6 of STO aborts the write
    do_reset();
    wr(18, 8'hAA); wr(0, 8'hD2);
    pulse_go();
    for (int i = 0; i < 20; i++) begin
      if (phase == 3'd6) break;
      tick();
    end
    expect_v(S_PH, 6, "midrst_phase6");
    check_now();
    rst = 1;
    tick();
    rst = 0;
    expect_v(S_HALT, 1, "midrst_halt");
    expect_v(S_PC, 0, "midrst_pc");
    expect_v(S_CNT, 0, "midrst_cnt");
    check_now();
    expect_mem(18, 8'hAA, "midrst_mem");

    // pc wraps from 31 to 0
    wr(0, 8'hFF); wr(31, 8'h00);
    pulse_go();
    run_to_halt(30);
    expect_v(S_HALT, 1, "pcwrap_halt");
    expect_v(S_PC, 0, "pcwrap_pc");
    expect_v(S_CNT, 2, "pcwrap_cnt");
    check_now();

    // go with ext_we in the same cycle fetches the new word
    do_reset();
    go = 1; ext_we = 1; ext_addr = 0; ext_wdata = 8'h00;
    tick();
    go = 0; ext_we = 0;
    run_to_halt(20);
    expect_v(S_HALT, 1, "gowe_halt");
    expect_v(S_PC, 1, "gowe_pc");
    expect_v(S_CNT, 1, "gowe_cnt");
    check_now();
    expect_mem(0, 8'h00, "gowe_mem");

    // rst wins over go
    rst = 1; go = 1;
    tick();
    rst = 0; go = 0;
    tick();
    expect_v(S_HALT, 1, "rstprio_halt");
    expect_v(S_PC, 0, "rstprio_pc");
    check_now();

    tick();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
